// File: rtl/alu2_sequencer.sv
// alu2_sequencer: multi-cycle WIDTH-bit ALU front end driving an external
// 2-bit combinational ALU slice, least-significant bit pair first, chaining
// the slice carry between cycles.
//
// Ports:
//   aclk, aresetn          clock / asynchronous active-low reset
//   rx_cmd_*               command handshake, one-hot opcode, carry-in, operands
//   tx_cmd_ready           command ready (IDLE only, low during reset)
//   tx_slice_* / rx_slice_*  per-step slice drive and slice response
//   tx_result_valid / rx_result_ready  result handshake
//   tx_result, tx_*flag    assembled result and flags, valid in DONE only
module alu2_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             rx_cmd_valid,
  output logic             tx_cmd_ready,
  input  logic [5:0]       rx_cmd_op,
  input  logic             rx_cmd_carryflag,
  input  logic [WIDTH-1:0] rx_cmd_operand0,
  input  logic [WIDTH-1:0] rx_cmd_operand1,
  output logic [5:0]       tx_slice_what_op,
  output logic             tx_slice_carryflag,
  output logic [1:0]       tx_slice_operand0,
  output logic [1:0]       tx_slice_operand1,
  input  logic [1:0]       rx_slice_result,
  input  logic             rx_slice_carryflag,
  output logic             tx_result_valid,
  input  logic             rx_result_ready,
  output logic [WIDTH-1:0] tx_result,
  output logic             tx_carryflag,
  output logic             tx_zeroflag,
  output logic             tx_signflag,
  output logic             tx_errorflag
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             ready_q;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  logic             carry_q;
  logic             err_q;
  logic [CW-1:0]    cnt_q;
  logic [CW:0]      base;
  logic             accept;
  logic             onehot;
  logic             last_step;

  assign accept    = (state_q == S_IDLE) && ready_q && rx_cmd_valid;
  assign onehot    = (rx_cmd_op != '0) && ((rx_cmd_op & (rx_cmd_op - 6'd1)) == '0);
  assign last_step = (cnt_q == CW'(N - 1));
  assign base      = {cnt_q, 1'b0};

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = onehot ? S_RUN : S_DONE;
      S_RUN:  if (last_step) state_d = S_DONE;
      S_DONE: if (rx_result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is registered so it stays low while reset is held and rises on the
  // first edge after release, even though the state is already IDLE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_q <= 1'b0;
    else          ready_q <= (state_d == S_IDLE);
  end

  // Datapath: capture command, then accumulate one bit pair per RUN cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      op_q    <= rx_cmd_op;
      opa_q   <= rx_cmd_operand0;
      opb_q   <= rx_cmd_operand1;
      res_q   <= '0;
      carry_q <= onehot ? rx_cmd_carryflag : 1'b0;
      err_q   <= !onehot;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      res_q[base +: 2] <= rx_slice_result;
      carry_q          <= rx_slice_carryflag;
      cnt_q            <= cnt_q + CW'(1);
    end
  end

  // Output logic: slice driven only in RUN, result/flags only in DONE
  always_comb begin
    tx_cmd_ready       = ready_q;
    tx_slice_what_op   = '0;
    tx_slice_carryflag = 1'b0;
    tx_slice_operand0  = '0;
    tx_slice_operand1  = '0;
    tx_result_valid    = 1'b0;
    tx_result          = '0;
    tx_carryflag       = 1'b0;
    tx_zeroflag        = 1'b0;
    tx_signflag        = 1'b0;
    tx_errorflag       = 1'b0;
    unique case (state_q)
      S_RUN: begin
        tx_slice_what_op   = op_q;
        tx_slice_carryflag = carry_q;
        tx_slice_operand0  = opa_q[base +: 2];
        tx_slice_operand1  = opb_q[base +: 2];
      end
      S_DONE: begin
        tx_result_valid = 1'b1;
        tx_result       = res_q;
        tx_carryflag    = carry_q;
        tx_zeroflag     = (res_q == '0);
        tx_signflag     = res_q[WIDTH-1];
        tx_errorflag    = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu2_sequencer.sv
module tb_alu2_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = WIDTH / 2;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_ROT = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b001000;
  localparam logic [5:0] OP_OR  = 6'b010000;
  localparam logic [5:0] OP_XOR = 6'b100000;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             rx_cmd_valid;
  logic             tx_cmd_ready;
  logic [5:0]       rx_cmd_op;
  logic             rx_cmd_carryflag;
  logic [WIDTH-1:0] rx_cmd_operand0, rx_cmd_operand1;
  logic [5:0]       tx_slice_what_op;
  logic             tx_slice_carryflag;
  logic [1:0]       tx_slice_operand0, tx_slice_operand1;
  logic [1:0]       rx_slice_result;
  logic             rx_slice_carryflag;
  logic             tx_result_valid;
  logic             rx_result_ready;
  logic [WIDTH-1:0] tx_result;
  logic             tx_carryflag, tx_zeroflag, tx_signflag, tx_errorflag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  alu2_sequencer #(.WIDTH(WIDTH)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .rx_cmd_valid       (rx_cmd_valid),
    .tx_cmd_ready       (tx_cmd_ready),
    .rx_cmd_op          (rx_cmd_op),
    .rx_cmd_carryflag   (rx_cmd_carryflag),
    .rx_cmd_operand0    (rx_cmd_operand0),
    .rx_cmd_operand1    (rx_cmd_operand1),
    .tx_slice_what_op   (tx_slice_what_op),
    .tx_slice_carryflag (tx_slice_carryflag),
    .tx_slice_operand0  (tx_slice_operand0),
    .tx_slice_operand1  (tx_slice_operand1),
    .rx_slice_result    (rx_slice_result),
    .rx_slice_carryflag (rx_slice_carryflag),
    .tx_result_valid    (tx_result_valid),
    .rx_result_ready    (rx_result_ready),
    .tx_result          (tx_result),
    .tx_carryflag       (tx_carryflag),
    .tx_zeroflag        (tx_zeroflag),
    .tx_signflag        (tx_signflag),
    .tx_errorflag       (tx_errorflag)
  );

  // External 2-bit slice: sub is a + ~b + cin, rot shifts left through carry
  always_comb begin
    logic [2:0] s;
    s = '0;
    rx_slice_result    = '0;
    rx_slice_carryflag = 1'b0;
    case (tx_slice_what_op)
      OP_ADD: begin
        s = {1'b0, tx_slice_operand0} + {1'b0, tx_slice_operand1} + {2'b0, tx_slice_carryflag};
        rx_slice_result = s[1:0]; rx_slice_carryflag = s[2];
      end
      OP_SUB: begin
        s = {1'b0, tx_slice_operand0} + {1'b0, ~tx_slice_operand1} + {2'b0, tx_slice_carryflag};
        rx_slice_result = s[1:0]; rx_slice_carryflag = s[2];
      end
      OP_ROT: begin
        rx_slice_result    = {tx_slice_operand0[0], tx_slice_carryflag};
        rx_slice_carryflag = tx_slice_operand0[1];
      end
      OP_AND: rx_slice_result = tx_slice_operand0 & tx_slice_operand1;
      OP_OR:  rx_slice_result = tx_slice_operand0 | tx_slice_operand1;
      OP_XOR: rx_slice_result = tx_slice_operand0 ^ tx_slice_operand1;
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command and return the number of edges after the accept edge
  // until tx_result_valid is seen (bounded).
  task automatic issue(input logic [5:0] op, input logic cin,
                       input logic [15:0] a, input logic [15:0] b, output int lat);
    int guard;
    guard = 0;
    while (!tx_cmd_ready && guard < 50) begin
      @(posedge aclk); #1; guard++;
    end
    check_eq("cmd_ready_before_issue", tx_cmd_ready, 1);
    rx_cmd_valid = 1'b1; rx_cmd_op = op; rx_cmd_carryflag = cin;
    rx_cmd_operand0 = a; rx_cmd_operand1 = b;
    @(posedge aclk); #1;
    rx_cmd_valid = 1'b0;
    if ($onehot(op)) begin
      check_eq("step0_slice_op", tx_slice_what_op, op);
      check_eq("step0_slice_cin", tx_slice_carryflag, cin);
      check_eq("step0_slice_a", tx_slice_operand0, a[1:0]);
      check_eq("step0_slice_b", tx_slice_operand1, b[1:0]);
      check_eq("run_cmd_ready", tx_cmd_ready, 0);
    end else begin
      check_eq("err_slice_op", tx_slice_what_op, 0);
    end
    lat = 0;
    while (!tx_result_valid && lat < 50) begin
      @(posedge aclk); #1; lat++;
    end
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic cin,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] e_res, input logic e_c, input logic e_z,
                     input logic e_s, input logic e_e, input int e_lat);
    int lat;
    issue(op, cin, a, b, lat);
    check_eq({tag, "_latency"}, lat, e_lat);
    check_eq({tag, "_valid"}, tx_result_valid, 1);
    check_eq({tag, "_result"}, tx_result, e_res);
    check_eq({tag, "_carry"}, tx_carryflag, e_c);
    check_eq({tag, "_zero"}, tx_zeroflag, e_z);
    check_eq({tag, "_sign"}, tx_signflag, e_s);
    check_eq({tag, "_error"}, tx_errorflag, e_e);
    check_eq({tag, "_ready_in_done"}, tx_cmd_ready, 0);
    check_eq({tag, "_slice_op_done"}, tx_slice_what_op, 0);
    @(posedge aclk); #1;
    check_eq({tag, "_valid_drop"}, tx_result_valid, 0);
    check_eq({tag, "_ready_rise"}, tx_cmd_ready, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, tx_result_valid, 0);
    check_eq({tag, "_result"}, tx_result, 0);
    check_eq({tag, "_flags"}, {tx_carryflag, tx_zeroflag, tx_signflag, tx_errorflag}, 0);
    check_eq({tag, "_slice"}, {tx_slice_what_op, tx_slice_carryflag,
                               tx_slice_operand0, tx_slice_operand1}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int seen;
    aresetn = 1'b0; rx_cmd_valid = 1'b0; rx_cmd_op = '0; rx_cmd_carryflag = 1'b0;
    rx_cmd_operand0 = '0; rx_cmd_operand1 = '0; rx_result_ready = 1'b1;

    // Reset values
    #12;
    check_eq("reset_cmd_ready", tx_cmd_ready, 0);
    check_idle_outputs("reset");
    #10 aresetn = 1'b1;
    #1 check_eq("ready_before_first_edge", tx_cmd_ready, 0);
    @(posedge aclk); #1;
    check_eq("ready_after_first_edge", tx_cmd_ready, 1);

    // Test 1-3: arithmetic and logic results
    run("add_ff_1",   OP_ADD, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 0, N);
    run("add_ffff_1", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0, N);
    run("add_cin",    OP_ADD, 1'b1, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 0, N);
    run("xor_same",   OP_XOR, 1'b0, 16'hA5A5, 16'hA5A5, 16'h0000, 0, 1, 0, 0, N);
    run("and_8001",   OP_AND, 1'b0, 16'h8001, 16'hFFFF, 16'h8001, 0, 0, 1, 0, N);
    run("sub_5_3",    OP_SUB, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1, 0, 0, 0, N);
    run("rot_8001",   OP_ROT, 1'b0, 16'h8001, 16'h0000, 16'h0002, 1, 0, 0, 0, N);
    run("or_mix",     OP_OR,  1'b0, 16'h1200, 16'h0034, 16'h1234, 0, 0, 0, 0, N);

    // Test 4: back-pressure, extra commands ignored
    rx_result_ready = 1'b0;
    issue(OP_ADD, 1'b0, 16'h0003, 16'h0004, lat);
    check_eq("bp_latency", lat, N);
    for (int i = 0; i < 5; i++) begin
      rx_cmd_valid = ~rx_cmd_valid; rx_cmd_op = OP_XOR;
      rx_cmd_operand0 = 16'hFFFF; rx_cmd_operand1 = 16'h0F0F;
      @(posedge aclk); #1;
      check_eq("bp_valid_hold", tx_result_valid, 1);
      check_eq("bp_result_hold", tx_result, 16'h0007);
      check_eq("bp_cmd_ready_low", tx_cmd_ready, 0);
      check_eq("bp_slice_idle", tx_slice_what_op, 0);
    end
    rx_cmd_valid = 1'b0;
    rx_result_ready = 1'b1;
    @(posedge aclk); #1;
    check_eq("bp_valid_drop", tx_result_valid, 0);
    check_eq("bp_ready_rise", tx_cmd_ready, 1);
    repeat (3) @(posedge aclk);
    #1;
    check_eq("bp_no_extra_cmd", {tx_result_valid, tx_slice_what_op}, 0);

    // Test 5: non-one-hot opcode
    run("bad_op", 6'b000011, 1'b1, 16'h1234, 16'h5678, 16'h0000, 0, 1, 0, 1, 0);
    run("zero_op", 6'b000000, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 1, 0, 1, 0);

    // Test 6: reset during RUN step 3
    rx_cmd_valid = 1'b1; rx_cmd_op = OP_ADD; rx_cmd_carryflag = 1'b0;
    rx_cmd_operand0 = 16'hC0FF; rx_cmd_operand1 = 16'h0001;
    @(posedge aclk); #1;
    rx_cmd_valid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("step3_slice_a", tx_slice_operand0, 2'b11);
    check_eq("step3_slice_cin", tx_slice_carryflag, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    check_eq("abort_cmd_ready", tx_cmd_ready, 0);
    check_idle_outputs("abort");
    repeat (2) @(posedge aclk);
    #1 check_idle_outputs("abort_held");
    @(negedge aclk); aresetn = 1'b1;
    #1 check_eq("abort_ready_before_edge", tx_cmd_ready, 0);
    @(posedge aclk); #1;
    check_eq("abort_ready_after_edge", tx_cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (tx_result_valid) seen++;
      @(posedge aclk); #1;
    end
    check_eq("abort_no_valid_pulse", seen, 0);
    run("add_after_abort", OP_ADD, 1'b0, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0, N);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
